// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: derives SCLK/LRCK from clock_in and shifts stereo pairs out MSB first,
// with a one-deep holding buffer fed by a valid/ready handshake.
module i2s_tx_serializer #(
  parameter int SCLK_DIV     = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    clock_in,
  input  logic                    Reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    SCLK,
  output logic                    LRCK,
  output logic                    SDATA,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);

  // Slot bit idx of a sample: MSB first, zero pad past the sample width.
  function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] sample, input int idx);
    logic [SAMPLE_WIDTH-1:0] shifted;
    shifted = sample << idx;
    if (idx < SAMPLE_WIDTH) begin
      slot_bit = shifted[SAMPLE_WIDTH-1];
    end else begin
      slot_bit = 1'b0;
    end
  endfunction

  logic [CW-1:0]           count_q, count_d;
  logic                    sclk_q, sclk_d;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic                    buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_left_q, buf_left_d;
  logic [SAMPLE_WIDTH-1:0] buf_right_q, buf_right_d;
  logic [SAMPLE_WIDTH-1:0] frm_left_q, frm_left_d;
  logic [SAMPLE_WIDTH-1:0] frm_right_q, frm_right_d;
  logic                    wrap_s;
  logic                    fall_s;
  logic [BW-1:0]           b_s;

  assign sample_ready = !buf_full_q && !Reset;
  assign SCLK         = sclk_q;
  assign LRCK         = lrck_q;
  assign SDATA        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

  // Next-state logic: clock divider, handshake capture, and per-fall serial advance.
  always_comb begin
    count_d       = count_q;
    sclk_d        = sclk_q;
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    bit_cnt_d     = bit_cnt_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    buf_full_d    = buf_full_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    frm_left_d    = frm_left_q;
    frm_right_d   = frm_right_q;
    b_s           = '0;
    wrap_s        = (count_q == CNT_MAX);
    fall_s        = wrap_s && sclk_q;

    if (wrap_s) begin
      count_d = '0;
      sclk_d  = ~sclk_q;
    end else begin
      count_d = count_q + CW'(1);
    end

    if (sample_valid && sample_ready) begin
      buf_full_d  = 1'b1;
      buf_left_d  = sample_left;
      buf_right_d = sample_right;
    end else begin
      buf_full_d  = buf_full_q;
    end

    if (fall_s) begin
      b_s       = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
      bit_cnt_d = b_s;
      lrck_d    = (int'(b_s) >= SLOT_WIDTH);
      if (b_s == '0) begin
        // Tail bit comes from the outgoing frame before it is replaced.
        sdata_d       = slot_bit(frm_right_q, SLOT_WIDTH - 1);
        frame_start_d = 1'b1;
        if (buf_full_q) begin
          frm_left_d  = buf_left_q;
          frm_right_d = buf_right_q;
          buf_full_d  = 1'b0;
        end else if (sample_valid) begin
          frm_left_d  = sample_left;
          frm_right_d = sample_right;
          buf_full_d  = 1'b0;
        end else begin
          frm_left_d  = '0;
          frm_right_d = '0;
          underrun_d  = 1'b1;
        end
      end else if (int'(b_s) <= SLOT_WIDTH) begin
        sdata_d = slot_bit(frm_left_q, int'(b_s) - 1);
      end else begin
        sdata_d = slot_bit(frm_right_q, int'(b_s) - 1 - SLOT_WIDTH);
      end
    end else begin
      b_s = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock_in) begin
    if (Reset) begin
      count_q       <= '0;
      sclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      bit_cnt_q     <= BIT_LAST;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      frm_left_q    <= '0;
      frm_right_q   <= '0;
    end else begin
      count_q       <= count_d;
      sclk_q        <= sclk_d;
      lrck_q        <= lrck_d;
      sdata_q       <= sdata_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      buf_full_q    <= buf_full_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
      frm_left_q    <= frm_left_d;
      frm_right_q   <= frm_right_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: timing-based reference model checked every cycle, directed
// literal scenarios, and a second instance with SLOT_WIDTH equal to SAMPLE_WIDTH for the tail bit.
module tb_i2s_tx_serializer;

  localparam int SD = 2;
  localparam int SL = 32;

  logic        clk;
  logic        rst, sv;
  logic [15:0] sl, sr;
  logic        sample_ready, SCLK, LRCK, SDATA, frame_start, underrun;

  logic        rst2, sv2;
  logic [15:0] sl2, sr2;
  logic        ready2, sclk2, lrck2, sd2, fs2, un2;
  logic        d2_done;

  int n_cmp = 0;
  int n_bad = 0;

  i2s_tx_serializer #(.SCLK_DIV(SD), .SAMPLE_WIDTH(16), .SLOT_WIDTH(SL)) dut (
    .clock_in(clk), .Reset(rst), .sample_left(sl), .sample_right(sr), .sample_valid(sv),
    .sample_ready(sample_ready), .SCLK(SCLK), .LRCK(LRCK), .SDATA(SDATA),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_tx_serializer #(.SCLK_DIV(1), .SAMPLE_WIDTH(16), .SLOT_WIDTH(16)) dut2 (
    .clock_in(clk), .Reset(rst2), .sample_left(sl2), .sample_right(sr2), .sample_valid(sv2),
    .sample_ready(ready2), .SCLK(sclk2), .LRCK(lrck2), .SDATA(sd2),
    .frame_start(fs2), .underrun(un2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic bitof(input logic [15:0] s, input int i);
    if (i < 16) return s[15 - i];
    return 1'b0;
  endfunction

  // Reference model: everything follows from the number of edges since reset release.
  int          m_n, m_b;
  logic        m_live = 1'b0;
  logic        m_sclk, m_lrck, m_sdata, m_fs, m_un, m_full;
  logic [15:0] m_bl, m_br, m_fl, m_fr;

  always @(posedge clk) begin : model
    int          n, k, b;
    logic        full_n, lrck_n, sd_n, fs_n, un_n;
    logic [15:0] bl_n, br_n, fl_n, fr_n;
    if (rst) begin
      m_live <= 1'b1; m_n <= 0; m_b <= 2 * SL - 1; m_full <= 1'b0;
      m_bl <= '0; m_br <= '0; m_fl <= '0; m_fr <= '0;
      m_sclk <= 1'b0; m_lrck <= 1'b0; m_sdata <= 1'b0; m_fs <= 1'b0; m_un <= 1'b0;
    end else begin
      n = m_n + 1; b = m_b; full_n = m_full; lrck_n = m_lrck; sd_n = m_sdata;
      fs_n = 1'b0; un_n = 1'b0; bl_n = m_bl; br_n = m_br; fl_n = m_fl; fr_n = m_fr;
      if (sv && !m_full) begin
        full_n = 1'b1; bl_n = sl; br_n = sr;
      end
      if (n % (2 * SD) == 0) begin
        k = n / (2 * SD);
        b = (k - 1) % (2 * SL);
        lrck_n = (b >= SL);
        if (b == 0) begin
          sd_n = bitof(m_fr, SL - 1);
          fs_n = 1'b1;
          if (m_full) begin
            fl_n = m_bl; fr_n = m_br; full_n = 1'b0;
          end else if (sv) begin
            fl_n = sl; fr_n = sr; full_n = 1'b0;
          end else begin
            fl_n = '0; fr_n = '0; un_n = 1'b1;
          end
        end else if (b <= SL) begin
          sd_n = bitof(m_fl, b - 1);
        end else begin
          sd_n = bitof(m_fr, b - 1 - SL);
        end
      end
      m_n <= n; m_b <= b; m_full <= full_n; m_bl <= bl_n; m_br <= br_n;
      m_fl <= fl_n; m_fr <= fr_n; m_sclk <= ((n / SD) % 2) == 1;
      m_lrck <= lrck_n; m_sdata <= sd_n; m_fs <= fs_n; m_un <= un_n;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("sclk", SCLK, m_sclk);
      chk("lrck", LRCK, m_lrck);
      chk("sdata", SDATA, m_sdata);
      chk("frame_start", frame_start, m_fs);
      chk("underrun", underrun, m_un);
      chk("ready", sample_ready, !m_full && !rst);
    end
  end

  // Expects Reset to have just been released; checks the first four edges literally.
  task automatic check_restart(input logic exp_un, input string tag);
    step();
    sv = 1'b0;
    chk({tag, "_e1_sclk"}, SCLK, 1'b0);
    chk({tag, "_e1_fs"}, frame_start, 1'b0);
    step();
    chk({tag, "_e2_sclk"}, SCLK, 1'b1);
    step();
    chk({tag, "_e3_sclk"}, SCLK, 1'b1);
    step();
    chk({tag, "_e4_sclk"}, SCLK, 1'b0);
    chk({tag, "_e4_fs"}, frame_start, 1'b1);
    chk({tag, "_e4_un"}, underrun, exp_un);
    chk({tag, "_e4_lrck"}, LRCK, 1'b0);
    chk({tag, "_e4_sdata"}, SDATA, 1'b0);
  endtask

  // Second instance: slot equals sample width, so the tail bit carries right-sample LSB.
  initial begin
    int fsn, cyc;
    rst2 = 1'b1; sv2 = 1'b1; sl2 = 16'h1234; sr2 = 16'h0001; d2_done = 1'b0;
    fsn = 0; cyc = 0;
    repeat (3) step();
    rst2 = 1'b0;
    while (fsn < 2 && cyc < 400) begin
      step();
      cyc++;
      if (fs2) begin
        fsn++;
        if (fsn == 1) begin
          chk("d2_first_un", un2, 1'b0);
          chk("d2_first_tail", sd2, 1'b0);
        end else begin
          chk("d2_tail", sd2, 1'b1);
          chk("d2_lrck", lrck2, 1'b0);
        end
      end
    end
    chk("d2_loads", 64'(fsn), 64'd2);
    d2_done = 1'b1;
  end

  initial begin
    logic [63:0] sd_w, lr_w, exp_sd, exp_lr;
    logic [15:0] by_l;
    int xf, fs, un, cyc, pct;
    rst = 1'b1; sv = 1'b0; sl = 16'h0000; sr = 16'h0000;
    repeat (3) step();

    // Release with no samples
    rst = 1'b0;
    check_restart(1'b1, "s1");
    repeat (10) step();

    // One pair loaded before the first fall
    rst = 1'b1;
    step(); step();
    rst = 1'b0; sv = 1'b1; sl = 16'hA5F0; sr = 16'h8001;
    check_restart(1'b0, "s2");
    sd_w[63] = SDATA; lr_w[63] = LRCK;
    for (int b = 1; b < 64; b++) begin
      repeat (4) step();
      sd_w[63 - b] = SDATA;
      lr_w[63 - b] = LRCK;
    end
    exp_sd = {1'b0, 16'hA5F0, 16'h0000, 16'h8001, 15'h0000};
    exp_lr = {32'h0000_0000, 32'hFFFF_FFFF};
    chk("s2_sdata_frame", sd_w, exp_sd);
    chk("s2_lrck_frame", lr_w, exp_lr);

    // Continuous valid: one transfer per frame after the first fill
    sv = 1'b1; xf = 0; fs = 0; un = 0; cyc = 0;
    while (fs < 5 && cyc < 2000) begin
      sl = 16'($urandom); sr = 16'($urandom);
      if (sv && sample_ready) xf++;
      step();
      cyc++;
      if (frame_start) fs++;
      if (underrun) un++;
    end
    if (sv && sample_ready) xf++;
    step();
    chk("s3_frames", 64'(fs), 64'd5);
    chk("s3_xfers", 64'(xf), 64'd6);
    chk("s3_underruns", 64'(un), 64'd0);

    // Drain, then present a pair only on a load cycle (bypass)
    sv = 1'b0; cyc = 0;
    while (!underrun && cyc < 700) begin step(); cyc++; end
    chk("s4_drained", underrun, 1'b1);
    cyc = 0;
    while (m_n % 256 != 3 && cyc < 300) begin step(); cyc++; end
    by_l = 16'($urandom) | 16'h8000;
    sv = 1'b1; sl = by_l; sr = 16'($urandom);
    step();
    sv = 1'b0;
    chk("s4_bypass_fs", frame_start, 1'b1);
    chk("s4_bypass_un", underrun, 1'b0);
    repeat (4) step();
    chk("s4_left_msb", SDATA, by_l[15]);
    repeat (300) step();

    // Random traffic with a varying offered rate
    pct = 0;
    for (int c = 0; c < 1600; c++) begin
      if (c % 256 == 0) pct = (c / 256) % 2 == 0 ? int'($urandom_range(0, 10)) : int'($urandom_range(30, 100));
      sv = ($urandom_range(0, 99) < pct);
      sl = 16'($urandom); sr = 16'($urandom);
      step();
    end

    // Reset pulse mid-frame with a full buffer
    sv = 1'b1; cyc = 0;
    step();
    while (!(m_b == 20 && m_sclk) && cyc < 1000) begin step(); cyc++; end
    chk("s6_at_b20", 64'(m_b), 64'd20);
    chk("s6_buf_full", sample_ready, 1'b0);
    sv = 1'b0; rst = 1'b1;
    step();
    chk("s6_rst_sclk", SCLK, 1'b0);
    chk("s6_rst_lrck", LRCK, 1'b0);
    chk("s6_rst_sdata", SDATA, 1'b0);
    chk("s6_rst_ready", sample_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("s6_ready_after", sample_ready, 1'b1);
    check_restart(1'b1, "s6");
    repeat (20) step();

    chk("d2_finished", d2_done, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
